// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

   // Transmit frame sequencing
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // par_mode encodings; 2'b11 behaves as none
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Legal data-bits range per frame
   localparam int DATA_BITS_MIN = 5;
   localparam int DATA_BITS_MAX = 9;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - down-counting bit-period timer, bit_end when count reaches zero
module uart_bit_timer #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] div_in,
   output logic             bit_end
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   // Reload at each bit start, otherwise count down and park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = div_in;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - DIV_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter; parity built only with UART_TX_PARITY_EN
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     div,
   input  logic                 stop2,
   input  logic [1:0]           par_mode,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic                 stop2_q, stop2_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic                 par_en_q, par_en_d;
   logic                 par_bit_q, par_bit_d;
`else
   logic                 unused_par;
   assign unused_par = ^par_mode;
`endif

   logic             bit_end;
   logic             accept;
   logic             last_stop;
   logic             timer_load;
   logic [DIV_W-1:0] timer_div;

   assign last_stop  = (state_q == STOP) && (!stop2_q || stop_cnt_q);
   assign done       = last_stop && bit_end;
   assign busy       = (state_q != IDLE);
   assign tx_ready   = (state_q == IDLE) || done;
   assign accept     = tx_valid && tx_ready;
   assign tx         = tx_q;
   // A new frame takes its period from the port, later bits from the latched copy
   assign timer_load = accept || (busy && bit_end);
   assign timer_div  = accept ? div : div_q;

   uart_bit_timer #(
      .DIV_W (DIV_W)
   ) u_bit_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (timer_load),
      .div_in  (timer_div),
      .bit_end (bit_end)
   );

   // Next-state, shift register, counters and serial line value
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      div_d      = div_q;
      stop2_d    = stop2_q;
      stop_cnt_d = stop_cnt_q;
      tx_d       = tx_q;
`ifdef UART_TX_PARITY_EN
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
`endif
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
         end
         START: begin
            if (bit_end) begin
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = 4'd0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  if (par_en_q) begin
                     tx_d    = par_bit_q;
                     state_d = PARITY;
                  end else begin
                     tx_d       = 1'b1;
                     stop_cnt_d = 1'b0;
                     state_d    = STOP;
                  end
`else
                  tx_d       = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = STOP;
`endif
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (last_stop) begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
      // Accept overrides: from IDLE or the done cycle, go straight to START
      if (accept) begin
         shift_d    = tx_data;
         div_d      = div;
         stop2_d    = stop2;
         stop_cnt_d = 1'b0;
         bit_cnt_d  = 4'd0;
         tx_d       = 1'b0;
         state_d    = START;
`ifdef UART_TX_PARITY_EN
         par_en_d   = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
         par_bit_d  = (par_mode == PAR_ODD) ? ~^tx_data : ^tx_data;
`endif
      end
   end

   // State and output registers; reset forces the line idle at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= 4'd0;
         div_q      <= '0;
         stop2_q    <= 1'b0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         div_q      <= div_d;
         stop2_q    <= stop2_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

   logic        clk;
   logic        rst;
   logic [15:0] div;
   logic        stop2;
   logic [1:0]  par_mode;
   logic [7:0]  tx_data8;
   logic        tx_valid8;
   logic        tx_ready8, tx8, busy8, done8;
   logic [4:0]  tx_data5;
   logic        tx_valid5;
   logic        tx_ready5, tx5, busy5, done5;

   int checks;
   int errors;

   uart_tx_frame #(.DATA_BITS(8), .DIV_W(16)) u_dut8 (
      .clk      (clk),
      .rst      (rst),
      .div      (div),
      .stop2    (stop2),
      .par_mode (par_mode),
      .tx_data  (tx_data8),
      .tx_valid (tx_valid8),
      .tx_ready (tx_ready8),
      .tx       (tx8),
      .busy     (busy8),
      .done     (done8)
   );

   uart_tx_frame #(.DATA_BITS(5), .DIV_W(16)) u_dut5 (
      .clk      (clk),
      .rst      (rst),
      .div      (div),
      .stop2    (stop2),
      .par_mode (par_mode),
      .tx_data  (tx_data5),
      .tx_valid (tx_valid5),
      .tx_ready (tx_ready5),
      .tx       (tx5),
      .busy     (busy5),
      .done     (done5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, req);
      end
   endtask

   task automatic check_idle(input string tag, input bit sel);
      chk({tag, "_tx"},    sel ? tx5       : tx8,       1'b1);
      chk({tag, "_ready"}, sel ? tx_ready5 : tx_ready8, 1'b1);
      chk({tag, "_busy"},  sel ? busy5     : busy8,     1'b0);
      chk({tag, "_done"},  sel ? done5     : done8,     1'b0);
   endtask

   // Called in the cycle after accept; returns positioned in the done cycle
   task automatic check_frame(input string tag, input bit sel, input int d,
                              input logic [15:0] bits, input int nbits);
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c <= d; c++) begin
            logic last;
            last = (b == nbits - 1) && (c == d);
            chk($sformatf("%s_tx_b%0d_c%0d", tag, b, c), sel ? tx5 : tx8, bits[b]);
            chk($sformatf("%s_done_b%0d_c%0d", tag, b, c), sel ? done5 : done8, last);
            chk($sformatf("%s_busy_b%0d_c%0d", tag, b, c), sel ? busy5 : busy8, 1'b1);
            chk($sformatf("%s_ready_b%0d_c%0d", tag, b, c), sel ? tx_ready5 : tx_ready8, last);
            if (!last) tick();
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      div       = 16'd0;
      stop2     = 1'b0;
      par_mode  = 2'b00;
      tx_data8  = 8'h00;
      tx_valid8 = 1'b0;
      tx_data5  = 5'h00;
      tx_valid5 = 1'b0;

      // 1: reset values, held and released
      tick();
      check_idle("rst8", 1'b0);
      check_idle("rst5", 1'b1);
      repeat (5) tick();
      rst = 1'b0;
      tick();
      tick();
      check_idle("rel8", 1'b0);
      check_idle("rel5", 1'b1);

      // 2: 8'h55, div=3, 1 stop, no parity -> done at clk 40
      div       = 16'd3;
      tx_data8  = 8'h55;
      tx_valid8 = 1'b1;
      tick();
      tx_valid8 = 1'b0;
      check_frame("f55", 1'b0, 3, 16'h02AA, 10);
      tick();
      check_idle("f55_end", 1'b0);

      // 3: parity modes (ignored when not built)
      par_mode  = 2'b01;
      tx_data8  = 8'h07;
      tx_valid8 = 1'b1;
      tick();
      tx_valid8 = 1'b0;
`ifdef UART_TX_PARITY_EN
      check_frame("even07", 1'b0, 3, 16'h060E, 11);
`else
      check_frame("even07", 1'b0, 3, 16'h020E, 10);
`endif
      tick();
      check_idle("even07_end", 1'b0);

      par_mode  = 2'b10;
      stop2     = 1'b1;
      tx_valid8 = 1'b1;
      tick();
      tx_valid8 = 1'b0;
`ifdef UART_TX_PARITY_EN
      check_frame("odd07s2", 1'b0, 3, 16'h0C0E, 12);
`else
      check_frame("odd07s2", 1'b0, 3, 16'h060E, 11);
`endif
      tick();
      check_idle("odd07s2_end", 1'b0);

      // 4: back-to-back A5 then 3C; data change mid-frame ignored
      par_mode  = 2'b00;
      stop2     = 1'b0;
      div       = 16'd2;
      tx_data8  = 8'hA5;
      tx_valid8 = 1'b1;
      tick();
      tx_data8  = 8'h3C;
      check_frame("bbA5", 1'b0, 2, 16'h034A, 10);
      tick();
      tx_valid8 = 1'b0;
      check_frame("bb3C", 1'b0, 2, 16'h0278, 10);
      tick();
      check_idle("bb_end", 1'b0);

      // 5: reset mid-DATA of 8'hFF, then 8'h0F with div=1 and two stops
      div       = 16'd3;
      tx_data8  = 8'hFF;
      tx_valid8 = 1'b1;
      tick();
      tx_valid8 = 1'b0;
      repeat (10) tick();
      chk("ff_busy_pre", busy8, 1'b1);
      rst = 1'b1;
      #1;
      check_idle("ff_rst", 1'b0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         chk($sformatf("ff_nodone_%0d", i), done8, 1'b0);
         chk($sformatf("ff_idle_tx_%0d", i), tx8, 1'b1);
         tick();
      end
      div       = 16'd1;
      stop2     = 1'b1;
      tx_data8  = 8'h0F;
      tx_valid8 = 1'b1;
      tick();
      tx_valid8 = 1'b0;
      check_frame("f0F", 1'b0, 1, 16'h061E, 11);
      tick();
      check_idle("f0F_end", 1'b0);

      // 6: 5-bit frame 5'h1B at div=0; div change mid-frame has no effect
      div       = 16'd0;
      stop2     = 1'b0;
      tx_data5  = 5'h1B;
      tx_valid5 = 1'b1;
      tick();
      tx_valid5 = 1'b0;
      div       = 16'd5;
      check_frame("f1B", 1'b1, 0, 16'h0076, 7);
      tick();
      check_idle("f1B_end", 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
